// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: divider op encodings and divider FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } divider_state_t;

  function automatic logic op_is_rem(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the radix-2 divider (combinational).
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted partial remainder keeps its carry-out bit so divisors with
  // the MSB set (unsigned ops) still compare correctly.
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            no_borrow;

  assign rem_sh    = {rem, quo[XLEN-1]};
  assign no_borrow = (rem_sh >= {1'b0, divisor});
  assign diff      = rem_sh[XLEN-1:0] + ~divisor + 1'b1;

  always_comb begin
    rem_next = rem_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (no_borrow) begin
      rem_next    = diff;
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider_64bit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
module seq_divider_64bit
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            dbz
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  divider_state_t  state;
  logic [1:0]      op_r;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] rem, quo, divisor;
  logic [CW-1:0]   count;

  logic            neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] rem_next, quo_next;

  assign neg_a = op_is_signed(op) & a[XLEN-1];
  assign neg_b = op_is_signed(op) & b[XLEN-1];
  assign abs_a = neg_a ? (~a + 1'b1) : a;
  assign abs_b = neg_b ? (~b + 1'b1) : b;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            sign_a  <= neg_a;
            sign_b  <= neg_b;
            quo     <= abs_a;
            divisor <= abs_b;
            rem     <= '0;
            count   <= '0;
            dbz     <= 1'b0;
            if (b == '0) begin
              result <= op_is_rem(op) ? a : '1;
              dbz    <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end else if (op_is_signed(op) && a == MIN_NEG && b == '1) begin
              result <= op_is_rem(op) ? '0 : a;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
          if (count == CW'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          // sign_a/sign_b are only ever set for signed ops
          if (op_is_rem(op_r)) result <= sign_a ? (~rem + 1'b1) : rem;
          else                 result <= (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_64bit.sv
// Scoreboard bench for seq_divider_64bit against a plain-arithmetic RV64M model.
module tb_seq_divider_64bit;
  import alu_pkg::*;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        busy, done, dbz;
  logic [63:0] result;

  seq_divider_64bit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int unsigned done_cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // done is seen during the cycle before the edge that samples it high,
  // so a latency of L edges shows up L-1 cycles after the accept edge.
  function automatic exp_t model(input logic [1:0] o, input logic [63:0] x,
                                 input logic [63:0] y, input int unsigned acc,
                                 input string tag);
    exp_t e;
    logic signed [63:0] sx, sy;
    int unsigned lat;
    sx = x;
    sy = y;
    e.dbz = 1'b0;
    lat = 66;
    if (y == 64'd0) begin
      e.res = o[1] ? x : {64{1'b1}};
      e.dbz = 1'b1;
      lat = 1;
    end else if (!o[0] && x == MIN_NEG && y == {64{1'b1}}) begin
      e.res = o[1] ? 64'd0 : x;
      lat = 1;
    end else begin
      case (o)
        2'b00:   e.res = sx / sy;
        2'b01:   e.res = x / y;
        2'b10:   e.res = sx % sy;
        default: e.res = x % y;
      endcase
    end
    e.done_cyc = acc + lat - 1;
    e.tag = tag;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done === 1'b1) begin
        if (sb.size() == 0) begin
          check64("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check64({e.tag, "_result"}, result, e.res);
          check64({e.tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
          check64({e.tag, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input string tag);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sb.push_back(model(o, x, y, cyc + 1, tag));
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  // pulse_at >= 0 pulses start with fresh operands at that negedge of the wait
  task automatic wait_done(input bit chk_busy, input int pulse_at, input string tag);
    bit seen = 0;
    bit busy_ok = 1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (i == pulse_at) begin
        op = 2'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} | 64'd1;
      end
      if (done === 1'b1) seen = 1;
      else if (chk_busy && busy !== 1'b1) busy_ok = 0;
    end
    start = 1'b0;
    check64({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (chk_busy) check64({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic run(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                     input string tag);
    bit special;
    special = (y == 64'd0) || (!o[0] && x == MIN_NEG && y == {64{1'b1}});
    issue(o, x, y, tag);
    wait_done(!special, -1, tag);
  endtask

  initial begin : driver
    logic [63:0] x, y;
    logic [1:0]  o;
    bit          seen;
    int unsigned d;

    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check64("reset_busy", 64'(busy), 64'd0);
    check64("reset_done", 64'(done), 64'd0);
    check64("reset_result", result, 64'd0);
    check64("reset_dbz", 64'(dbz), 64'd0);

    run(DIV_OP_DIVU, 64'd100, 64'd7, "divu_100_7");
    check64("divu_100_7_const", result, 64'd14);
    run(DIV_OP_REMU, 64'd100, 64'd7, "remu_100_7");
    check64("remu_100_7_const", result, 64'd2);
    run(DIV_OP_DIV, -64'sd100, 64'd7, "div_m100_7");
    check64("div_m100_7_const", result, 64'hFFFF_FFFF_FFFF_FFF2);
    run(DIV_OP_REM, -64'sd100, 64'd7, "rem_m100_7");
    check64("rem_m100_7_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run(DIV_OP_DIV, 64'd5, 64'd0, "div_by_zero");
    run(DIV_OP_REM, 64'd5, 64'd0, "rem_by_zero");
    run(DIV_OP_DIVU, 64'd9, 64'd3, "dbz_cleared");
    run(DIV_OP_DIV, MIN_NEG, {64{1'b1}}, "div_overflow");
    run(DIV_OP_REM, MIN_NEG, {64{1'b1}}, "rem_overflow");
    run(DIV_OP_DIVU, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE, "divu_big_divisor");
    run(DIV_OP_REMU, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE, "remu_big_divisor");
    run(DIV_OP_DIV, 64'd7, -64'sd2, "div_7_m2");
    run(DIV_OP_REM, -64'sd7, -64'sd2, "rem_m7_m2");

    // start pulsed mid-CALC must be ignored
    issue(DIV_OP_DIV, 64'd123456789, -64'sd1000, "mid_calc_pulse");
    wait_done(1, 10, "mid_calc_pulse");

    // start held high through CALC/FIX/DONE: only accepted on the next IDLE
    @(negedge clk);
    start = 1'b1;
    op = DIV_OP_DIVU;
    a = 64'd1000;
    b = 64'd3;
    sb.push_back(model(DIV_OP_DIVU, 64'd1000, 64'd3, cyc + 1, "held_first"));
    @(posedge clk);
    #1;
    op = DIV_OP_REMU;
    a = 64'd777;
    b = 64'd5;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check64("held_first_done_seen", 64'(seen), 64'd1);
    d = cyc;
    sb.push_back(model(DIV_OP_REMU, 64'd777, 64'd5, d + 2, "held_second"));
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1, -1, "held_second");

    // reset mid-CALC abandons the operation
    issue(DIV_OP_DIVU, 64'd999_999, 64'd13, "reset_mid");
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check64("midrst_busy", 64'(busy), 64'd0);
    check64("midrst_done", 64'(done), 64'd0);
    check64("midrst_result", result, 64'd0);
    run(DIV_OP_REM, -64'sd999_999, 64'd13, "after_reset");

    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom);
      x = {$urandom, $urandom};
      case ($urandom % 8)
        0: y = 64'd0;
        1: y = 64'($urandom % 16 + 1);
        2: begin x = MIN_NEG; y = {64{1'b1}}; end
        3: y = {1'b1, 31'($urandom), $urandom};
        4: y = 64'($urandom);
        default: y = {$urandom, $urandom};
      endcase
      run(o, x, y, $sformatf("rand%0d_op%0d", n, o));
    end

    repeat (3) @(negedge clk);
    check64("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
